// File: rtl/barrel_shifter_pipe.sv
// Pipelined multi-mode barrel shifter: one log2 shift level per register stage,
// MSB level first, with a global-stall valid/ready handshake.
module barrel_shifter_pipe #(
  parameter int WIDTH = 16,
  parameter int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       op,
    input logic             sgn,
    input int               sh
  );
    logic [WIDTH-1:0] fill;
    fill = sgn ? ~({WIDTH{1'b1}} >> sh) : '0;
    step = d;
    unique case (1'b1)
      (op == OP_SLL): step = d << sh;
      (op == OP_SRL): step = d >> sh;
      (op == OP_SRA): step = (d >> sh) | fill;
      (op == OP_ROL): step = (d << sh) | (d >> (WIDTH - sh));
      (op == OP_ROR): step = (d >> sh) | (d << (WIDTH - sh));
      default:        step = d;
    endcase
  endfunction

  // Final stage keeps only valid/data; control fields are dead past it.
  logic             vld   [LOG2W];
  logic [WIDTH-1:0] dat   [LOG2W];
  logic [LOG2W-1:0] amt_r [LOG2W-1];
  logic [2:0]       op_r  [LOG2W-1];
  logic             sgn_r [LOG2W-1];

  logic             src_v [LOG2W];
  logic [WIDTH-1:0] src_d [LOG2W];
  logic [LOG2W-1:0] src_a [LOG2W];
  logic [2:0]       src_o [LOG2W];
  logic             src_s [LOG2W];
  logic [WIDTH-1:0] nxt_d [LOG2W];

  logic advance;

  assign out_valid = vld[LOG2W-1];
  assign out_data  = dat[LOG2W-1];
  assign out_zero  = (out_data == '0);
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  always_comb begin
    src_v[0] = in_valid;
    src_d[0] = in_data;
    src_a[0] = in_amt;
    src_o[0] = in_op;
    src_s[0] = in_data[WIDTH-1];
    for (int k = 1; k < LOG2W; k++) begin
      src_v[k] = vld[k-1];
      src_d[k] = dat[k-1];
      src_a[k] = amt_r[k-1];
      src_o[k] = op_r[k-1];
      src_s[k] = sgn_r[k-1];
    end
    for (int k = 0; k < LOG2W; k++) begin
      nxt_d[k] = src_d[k];
      if (src_a[k][LOG2W-1-k])
        nxt_d[k] = step(src_d[k], src_o[k], src_s[k],
                        1 << (LOG2W - 1 - k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LOG2W; k++) begin
        vld[k] <= 1'b0;
        dat[k] <= '0;
      end
      for (int k = 0; k < LOG2W - 1; k++) begin
        amt_r[k] <= '0;
        op_r[k]  <= '0;
        sgn_r[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < LOG2W; k++) begin
        vld[k] <= src_v[k];
        dat[k] <= nxt_d[k];
      end
      for (int k = 0; k < LOG2W - 1; k++) begin
        amt_r[k] <= src_a[k];
        op_r[k]  <= src_o[k];
        sgn_r[k] <= src_s[k];
      end
    end
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Bench for barrel_shifter_pipe: WIDTH 16 directed + random, WIDTH 8/32 random,
// all scored against an arithmetic reference model.
module tb_barrel_shifter_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] d, input int a,
                                        input int o, input int w);
    logic [63:0] m, r;
    m = (64'd1 << w) - 64'd1;
    d = d & m;
    case (o)
      0: r = d << a;
      1: r = d >> a;
      2: r = (d >> a) | (d[w-1] ? (m & ~(m >> a)) : 64'd0);
      3: r = (d << a) | (d >> (w - a));
      4: r = (d >> a) | (d << (w - a));
      default: r = d;
    endcase
    return r & m;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int W = (gi == 0) ? 16 : ((gi == 1) ? 8 : 32);
    localparam int L = $clog2(W);

    logic rst_n, iv, ir, ov, orr, oz;
    logic [W-1:0] id, od, hold_d;
    logic [L-1:0] ia;
    logic [2:0] iop;
    logic hold = 1'b0;
    bit done = 1'b0;
    logic [63:0] q[$];

    barrel_shifter_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv), .in_ready(ir),
      .in_data(id), .in_amt(ia), .in_op(iop),
      .out_valid(ov), .out_ready(orr),
      .out_data(od), .out_zero(oz)
    );

    always @(negedge clk) begin
      logic [63:0] e;
      if (!rst_n) begin
        q.delete();
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk($sformatf("w%0d hold valid", W), ov, 1);
          chk($sformatf("w%0d hold data", W), od, hold_d);
        end
        if (ov && orr) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL w%0d unexpected output: got %0h expected none",
                     W, od);
          end else begin
            e = q.pop_front();
            chk($sformatf("w%0d data", W), od, e);
            chk($sformatf("w%0d zero", W), oz, e == 0);
          end
        end
        if (iv && ir) q.push_back(model(id, ia, iop, W));
        hold = ov && !orr;
        hold_d = od;
      end
    end

    task automatic do_reset();
      rst_n = 1'b0;
      iv = 1'b0; orr = 1'b1;
      id = '0; ia = '0; iop = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
    endtask

    task automatic rand_phase(input int n);
      for (int c = 0; c < n; c++) begin
        iv  = ($urandom_range(0, 9) < 7);
        id  = W'($urandom());
        ia  = L'($urandom_range(0, W - 1));
        iop = 3'($urandom_range(0, 7));
        orr = ($urandom_range(0, 9) < 7);
        @(posedge clk); #1;
      end
      iv = 1'b0; orr = 1'b1;
      repeat (L + 4) @(posedge clk);
      #1 chk($sformatf("w%0d drain empty", W), q.size(), 0);
    endtask

    if (gi == 0) begin : d
      task automatic run_one(input logic [15:0] dv, input int a,
                             input int o, input logic [15:0] exp,
                             input string nm);
        int n;
        iv = 1'b1; id = dv; ia = 4'(a); iop = 3'(o); orr = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        n = 1;
        while (!ov && n < 20) begin
          @(posedge clk); #1;
          n++;
        end
        chk({nm, " latency"}, n, 4);
        chk({nm, " data"}, od, exp);
        chk({nm, " zero"}, oz, exp == 16'h0);
        @(posedge clk); #1;
      endtask

      initial begin
        int first, last, cnt;
        logic [15:0] hd;
        do_reset();
        chk("reset out_valid", ov, 0);
        chk("reset out_data", od, 0);
        chk("reset out_zero", oz, 1);
        chk("reset in_ready", ir, 1);

        chk("model sra", model(16'h8000, 4, 2, 16), 16'hF800);
        chk("model rol", model(16'h8001, 1, 3, 16), 16'h0003);
        chk("model ror8", model(8'h81, 3, 4, 8), 8'h30);

        run_one(16'h0001, 15, 0, 16'h8000, "sll15");
        run_one(16'h8000, 4, 2, 16'hF800, "sra4");
        run_one(16'h8000, 4, 1, 16'h0800, "srl4");
        run_one(16'h0001, 1, 1, 16'h0000, "srl_zero");
        run_one(16'h8001, 1, 3, 16'h0003, "rol1");
        run_one(16'h8001, 1, 4, 16'hC000, "ror1");
        run_one(16'h1234, 5, 7, 16'h1234, "pass");
        run_one(16'h8001, 0, 2, 16'h8001, "amt0");

        first = -1; last = 0; cnt = 0; orr = 1'b1;
        for (int i = 0; i < 14; i++) begin
          iv = (i < 8);
          id = 16'($urandom()); ia = 4'($urandom());
          iop = 3'($urandom_range(0, 4));
          @(posedge clk); #1;
          if (ov) begin
            cnt++;
            if (first < 0) first = i;
            last = i;
          end
        end
        iv = 1'b0;
        chk("b2b count", cnt, 8);
        chk("b2b span", last - first, 7);

        orr = 1'b0;
        for (int i = 0; i < 4; i++) begin
          iv = 1'b1; id = 16'($urandom()); ia = 4'($urandom());
          iop = 3'($urandom_range(0, 7));
          @(posedge clk); #1;
        end
        chk("stall full valid", ov, 1);
        id = 16'hA5A5; ia = 4'd3; iop = 3'd3;
        hd = od;
        repeat (5) begin
          @(posedge clk); #1;
          chk("stall in_ready", ir, 0);
          chk("stall data", od, hd);
        end
        orr = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("stall drain empty", q.size(), 0);

        orr = 1'b0;
        for (int i = 0; i < 4; i++) begin
          iv = 1'b1; id = 16'($urandom()); ia = 4'($urandom());
          iop = 3'($urandom_range(0, 4));
          @(posedge clk); #1;
        end
        iv = 1'b0;
        chk("pre-reset valid", ov, 1);
        rst_n = 1'b0;
        #1;
        chk("midreset out_valid", ov, 0);
        chk("midreset out_data", od, 0);
        chk("midreset out_zero", oz, 1);
        chk("midreset in_ready", ir, 1);
        orr = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1 chk("post-reset idle", ov, 0);

        rand_phase(800);
        done = 1'b1;
      end
    end else begin : r
      initial begin
        do_reset();
        rand_phase(1500);
        done = 1'b1;
      end
    end
  end

  initial begin
    int guard;
    guard = 0;
    while (!(g[0].done && g[1].done && g[2].done) && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 20000) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d cycles expected completion", guard);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
